// File: rtl/out_port_uart_tx_pkg.sv
// Shared definitions for out_port_uart_tx: FSM state encoding, UART frame
// layout and the parity helper used when OUT_PORT_UART_TX_PARITY_EN is defined.
package out_port_uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_STOP   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   DATA_BITS      = 8;
  localparam int   BYTES_PER_WORD = 2;
  localparam int   WORD_BITS      = DATA_BITS * BYTES_PER_WORD;

  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO with registered occupancy count; reads return the
// current head combinationally and a read pops it on the clock edge.
module out_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_wr;
  logic                  w_do_rd;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never frees a slot for a write until the following cycle.
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// OUT-port consumer: buffers 16-bit core writes and sends each as two UART
// frames, low byte first. Define OUT_PORT_UART_TX_PARITY_EN for even parity.
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT    = 104,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_overflow
);

  import out_port_uart_tx_pkg::*;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t                   r_state;
  logic [BAUD_W-1:0]        r_baud;
  logic [2:0]               r_bit_idx;
  logic                     r_byte_sel;
  logic [WORD_BITS-1:0]     r_shift;
  logic                     r_tx;
  logic                     r_overflow;
`ifdef OUT_PORT_UART_TX_PARITY_EN
  logic                     r_parity;
`endif

  logic [WORD_BITS-1:0]     w_fifo_data;
  logic                     w_full;
  logic                     w_empty;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic                     w_wr_accept;
  logic                     w_pop;
  logic                     w_bit_end;

  assign w_wr_accept = i_wr && !w_full;
  assign w_bit_end   = (r_baud == BAUD_LAST);

  // A word leaves the FIFO either when idle or at the very end of a high-byte
  // stop bit, which is what lets consecutive words run with no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) ||
                  ((r_state == ST_STOP) && w_bit_end && r_byte_sel));

  out_fifo #(
    .WIDTH      (WORD_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (w_wr_accept),
    .i_rd    (w_pop),
    .i_data  (i_data),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud <= '0;
    end else if ((r_state == ST_IDLE) || w_bit_end) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  // o_tx is registered and updated on the same edge as each state change,
  // so every bit cell is exactly CLKS_PER_BIT cycles wide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_shift    <= '0;
      r_tx       <= STOP_BIT;
`ifdef OUT_PORT_UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift    <= w_fifo_data;
            r_byte_sel <= 1'b0;
            r_tx       <= START_BIT;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
`ifdef OUT_PORT_UART_TX_PARITY_EN
            r_parity  <= even_parity(r_shift[DATA_BITS-1:0]);
`endif
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            // After eight shifts the high byte sits in the low bits.
            r_shift <= {1'b0, r_shift[WORD_BITS-1:1]};
            if (r_bit_idx == LAST_DATA_BIT) begin
`ifdef OUT_PORT_UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= STOP_BIT;
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef OUT_PORT_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= STOP_BIT;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (!r_byte_sel) begin
              r_byte_sel <= 1'b1;
              r_tx       <= START_BIT;
              r_state    <= ST_START;
            end else if (!w_empty) begin
              r_shift    <= w_fifo_data;
              r_byte_sel <= 1'b0;
              r_tx       <= START_BIT;
              r_state    <= ST_START;
            end else begin
              r_tx    <= STOP_BIT;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= STOP_BIT;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_wr && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_ready    = !w_full;
  assign o_tx       = r_tx;
  assign o_busy     = (r_state != ST_IDLE) || (w_count != '0);
  assign o_overflow = r_overflow;

endmodule
